// File: rtl/ps1_clock_pkg.sv
// Shared definitions for the serial Unix-timestamp receiver: FSM states and
// epoch constants.
package ps1_clock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int unsigned SECONDS_PER_DAY = 86400;

  // 2020-01-01 00:00:00 UTC expressed as Unix seconds.
  localparam logic [63:0] DEFAULT_EPOCH_OFFSET = 64'(18262) * 64'(SECONDS_PER_DAY);

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous input; INIT is the idle level
// forced while reset is high.
module sync2 #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/unix_ts_receiver.sv
// Receives a serial Unix timestamp frame, rebases it to a local epoch plus
// timezone offset, and then keeps it running from a 1 Hz strobe.
module unix_ts_receiver
  import ps1_clock_pkg::*;
#(
  parameter int          TS_WIDTH     = 32,
  parameter int          OUT_WIDTH    = 28,
  parameter logic [63:0] EPOCH_OFFSET = DEFAULT_EPOCH_OFFSET,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 unix_sclk,
  input  logic                 unix_data,
  input  logic                 unix_cs_n,
  input  logic                 tick_1hz,
  input  logic signed [17:0]   tz_offset,
  output logic [OUT_WIDTH-1:0] t,
  output logic                 t_valid,
  output logic                 load_pulse,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(TS_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TS_WIDTH + 1);

  state_t state, state_next;

  logic sclk_s, data_s, cs_s;
  logic sclk_d, cs_d;
  logic sclk_rise, cs_fall, cs_rise;

  logic [TS_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]    cnt;

  logic signed [65:0] base;
  logic               accept, base_neg, base_ovf;

  sync2 #(.INIT(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(unix_sclk), .q(sclk_s));
  sync2 #(.INIT(1'b0)) u_sync_data (.clk(clk), .reset(reset), .d(unix_data), .q(data_s));
  sync2 #(.INIT(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(unix_cs_n), .q(cs_s));

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Wide enough that no timestamp/offset combination can wrap before clamping.
  assign base = $signed({2'b00, 64'(shreg)})
              - $signed({2'b00, EPOCH_OFFSET})
              + $signed({{48{tz_offset[17]}}, tz_offset});

  assign accept   = (cnt == CNT_FULL) && (64'(shreg) >= EPOCH_OFFSET);
  assign base_neg = base[65];
  assign base_ovf = !base[65] && (|base[64:OUT_WIDTH]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      shreg      <= '0;
      cnt        <= '0;
      t          <= '0;
      t_valid    <= 1'b0;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sclk_d     <= sclk_s;
      cs_d       <= cs_s;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;

      // A load in CHECK is assigned later in this block, so it overrides the tick.
      if (tick_1hz && t_valid) t <= t + OUT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            if (cnt < CNT_FULL) begin
              if (LSB_FIRST) shreg <= {data_s, shreg[TS_WIDTH-1:1]};
              else           shreg <= {shreg[TS_WIDTH-2:0], data_s};
            end
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
          end
        end
        CHECK: begin
          if (accept) begin
            load_pulse <= 1'b1;
            t_valid    <= 1'b1;
            frame_err  <= base_ovf;
            if (base_neg)      t <= '0;
            else if (base_ovf) t <= '1;
            else               t <= base[OUT_WIDTH-1:0];
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unix_ts_receiver.sv
// Self-checking bench: an LSB-first and an MSB-first receiver see the same
// frames; a scoreboard checks every pulse against an arithmetic model.
module tb_unix_ts_receiver;

  localparam int     TSW   = 32;
  localparam int     OW    = 28;
  localparam longint EPOCH = 64'd1577836800;
  localparam longint T_MAX = (longint'(1) << OW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk_a = 1'b0, data_a = 1'b0, cs_a = 1'b1;
  logic sclk_b = 1'b0, data_b = 1'b0, cs_b = 1'b1;
  logic tick = 1'b0;
  logic signed [17:0] tz = '0;

  logic [OW-1:0] t_a, t_b;
  logic tv_a, tv_b, lp_a, lp_b, fe_a, fe_b;

  logic [30:0] exp_a[$];
  logic [30:0] exp_b[$];

  longint model_t = 0;
  bit     model_valid = 1'b0;
  int     n_vec = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;

  unix_ts_receiver #(.TS_WIDTH(TSW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .unix_sclk(sclk_a), .unix_data(data_a), .unix_cs_n(cs_a),
    .tick_1hz(tick), .tz_offset(tz), .t(t_a), .t_valid(tv_a), .load_pulse(lp_a), .frame_err(fe_a)
  );

  unix_ts_receiver #(.TS_WIDTH(TSW), .OUT_WIDTH(OW), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .unix_sclk(sclk_b), .unix_data(data_b), .unix_cs_n(cs_b),
    .tick_1hz(tick), .tz_offset(tz), .t(t_b), .t_valid(tv_b), .load_pulse(lp_b), .frame_err(fe_b)
  );

  task automatic check(input string name, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [30:0] pack(input bit ld, input bit er, input bit tv, input longint tt);
    return {ld, er, tv, OW'(tt)};
  endfunction

  // Monitor: any pulse must match the head of that receiver's expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (lp_a || fe_a) begin
        if (exp_a.size() == 0) check("unexpected_pulse_a", {lp_a, fe_a}, 0);
        else check("pulse_a", {lp_a, fe_a, tv_a, t_a}, exp_a.pop_front());
      end
      if (lp_b || fe_b) begin
        if (exp_b.size() == 0) check("unexpected_pulse_b", {lp_b, fe_b}, 0);
        else check("pulse_b", {lp_b, fe_b, tv_b, t_b}, exp_b.pop_front());
      end
    end
  end

  // Reference model: result of a frame follows directly from the acceptance rules.
  task automatic expect_frame(input longint val, input int nbits);
    longint base;
    logic [30:0] e;
    if (nbits != TSW || val < EPOCH) begin
      e = pack(1'b0, 1'b1, model_valid, model_t);
    end else begin
      base = val - EPOCH + longint'(tz);
      if (base < 0) begin
        model_t = 0;
        e = pack(1'b1, 1'b0, 1'b1, 0);
      end else if (base > T_MAX) begin
        model_t = T_MAX;
        e = pack(1'b1, 1'b1, 1'b1, T_MAX);
      end else begin
        model_t = base;
        e = pack(1'b1, 1'b0, 1'b1, base);
      end
      model_valid = 1'b1;
    end
    exp_a.push_back(e);
    exp_b.push_back(e);
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_a = 1'b0;
    cs_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bit(input logic a, input logic b);
    data_a = a;
    data_b = b;
    repeat (2) @(negedge clk);
    sclk_a = 1'b1;
    sclk_b = 1'b1;
    repeat (3) @(negedge clk);
    sclk_a = 1'b0;
    sclk_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Receiver A gets LSB first, receiver B the same value MSB first.
  task automatic send_bits(input logic [63:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(v[i], v[nbits-1-i]);
  endtask

  task automatic frame_end();
    repeat (2) @(negedge clk);
    cs_a = 1'b1;
    cs_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (k >= 80) begin
      check("drain_timeout", exp_a.size() + exp_b.size(), 0);
      exp_a.delete();
      exp_b.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input longint val, input int nbits);
    expect_frame(val, nbits);
    frame_begin();
    send_bits(val, nbits);
    frame_end();
    wait_drain();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (model_valid) model_t = (model_t + 1) & T_MAX;
    end
  endtask

  task automatic check_t(input string name);
    check({name, "_t_a"}, t_a, model_t);
    check({name, "_t_b"}, t_b, model_t);
    check({name, "_tv_a"}, tv_a, model_valid);
    check({name, "_tv_b"}, tv_b, model_valid);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint val;
    int     nbits;
    int     r;
    int     tzv;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    check_t("reset");
    check("reset_pulses_a", {lp_a, fe_a}, 0);
    check("reset_pulses_b", {lp_b, fe_b}, 0);

    tick_n(2);
    check_t("tick_invalid");

    run_frame(1000, TSW);
    check_t("below_epoch");

    tz = 18'sd0;
    run_frame(EPOCH, TSW);
    check_t("epoch_zero");

    tz = 18'sd19800;
    run_frame(EPOCH + 3600, TSW);
    check_t("tz_load");
    tick_n(5);
    check_t("after_5_ticks");

    run_frame(EPOCH + 7, TSW - 1);
    check_t("short_frame");
    run_frame(EPOCH + 7, TSW + 1);
    check_t("long_frame");

    tz = -18'sd12345;
    repeat (10) @(negedge clk);
    check_t("tz_idle_change");

    tz = -18'sd50400;
    run_frame(EPOCH + 10, TSW);
    check_t("clamp_low");

    tz = 18'sd0;
    run_frame(EPOCH + T_MAX + 6, TSW);
    check_t("clamp_high");
    tick_n(1);
    check_t("tick_wrap");

    run_frame(EPOCH - 1, TSW);
    run_frame(EPOCH + T_MAX, TSW);
    check_t("max_exact");

    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      val = EPOCH + longint'($urandom_range(0, 300000000));
      else if (r < 8) val = longint'($urandom());
      else            val = EPOCH + longint'($urandom_range(0, 100));
      nbits = TSW;
      if ($urandom_range(0, 7) == 0) nbits = ($urandom_range(0, 1) == 0) ? TSW - 1 : TSW + 1;
      tzv = int'($urandom_range(0, 100800)) - 50400;
      tz = 18'(tzv);
      run_frame(val, nbits);
    end
    check_t("random_end");

    // tick held high across the load: the loaded value must appear untouched.
    tz = 18'sd100;
    expect_frame(EPOCH + 5000, TSW);
    frame_begin();
    send_bits(EPOCH + 5000, TSW);
    frame_end();
    tick = 1'b1;
    repeat (12) @(negedge clk);
    tick = 1'b0;
    wait_drain();

    // Reset in the middle of a frame: the partial frame must leave no trace.
    frame_begin();
    send_bits(EPOCH + 42, 16);
    @(negedge clk);
    reset = 1'b1;
    cs_a = 1'b1; cs_b = 1'b1;
    sclk_a = 1'b0; sclk_b = 1'b0;
    data_a = 1'b0; data_b = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_t = 0;
    model_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_t("mid_frame_reset");
    tick_n(2);
    check_t("post_reset_tick");

    tz = 18'sd0;
    run_frame(EPOCH + 42, TSW);
    check_t("after_abort");

    repeat (10) @(negedge clk);
    check("final_queue_a", exp_a.size(), 0);
    check("final_queue_b", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
